// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. An accepted start latches a, b and cin. The
//   block then adds one bit per clock, LSB first. Each bit uses a full adder
//   built from two half adders and a registered carry. When the last bit is
//   done, the full sum and carry-out are published and done pulses for one
//   cycle. Partial results never reach the sum output.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request; accepted only in IDLE or DONE
//   a      in   WIDTH  operand A, sampled on an accepted start
//   b      in   WIDTH  operand B, sampled on an accepted start
//   cin    in   1      carry-in, sampled on an accepted start
//   busy   out  1      high while bits are being added
//   done   out  1      one-cycle pulse: sum/carry just updated
//   sum    out  WIDTH  result of the last completed add
//   carry  out  1      carry-out of the last completed add
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;

    // Full adder on the current LSBs, formed from two half adders.
    logic ha0_s, ha0_c, ha1_s, ha1_c, fa_c;

    assign ha0_s = a_sr_q[0] ^ b_sr_q[0];
    assign ha0_c = a_sr_q[0] & b_sr_q[0];
    assign ha1_s = ha0_s ^ c_q;
    assign ha1_c = ha0_s & c_q;
    assign fa_c  = ha0_c | ha1_c;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        carry_d = carry_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE accepts start exactly like IDLE, so ops can run back to back.
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            RUN: begin
                // start is ignored here: no restart, no queueing.
                a_sr_d             = a_sr_q >> 1;
                b_sr_d             = b_sr_q >> 1;
                res_d              = res_q >> 1;
                res_d[WIDTH-1]     = ha1_s;
                c_d                = fa_c;
                cnt_d              = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Publish only the complete result, on the RUN->DONE edge.
                    sum_d   = res_d;
                    carry_d = fa_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder. It uses one WIDTH=8 instance for the
//   scenario tests and one WIDTH=4 instance for the exhaustive sweep.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, carry8;
    logic [7:0] a8, b8, sum8;

    logic       start4, cin4, busy4, done4, carry4;
    logic [3:0] a4, b4, sum4;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .carry (carry8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .carry (carry4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one start cycle on the 8-bit DUT, then scrambles operands.
    task automatic start_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        start8 = 1'b1;
        a8     = av;
        b8     = bv;
        cin8   = cv;
        tick();
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
    endtask

    // Waits (bounded) for done on the 8-bit DUT. Reports the cycle count,
    // cycles with busy high, and whether sum/carry moved off the held value.
    task automatic wait_done8(input logic [7:0] held_sum, input logic held_carry,
                              output int cycles, output int busy_cycles, output bit changed);
        cycles      = 0;
        busy_cycles = 0;
        changed     = 1'b0;
        while (done8 !== 1'b1 && cycles < 20) begin
            if (busy8 === 1'b1) busy_cycles++;
            if (sum8 !== held_sum || carry8 !== held_carry) changed = 1'b1;
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start4 = 1'b0; a4 = 4'h0;  b4 = 4'h0;  cin4 = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy8, done8, carry8, sum8} !== 11'd0) begin
            failures++;
            $display("FAIL reset8: busy=%b done=%b carry=%b sum=%h, want all 0", busy8, done8, carry8, sum8);
        end
        checks++;
        if ({busy4, done4, carry4, sum4} !== 7'd0) begin
            failures++;
            $display("FAIL reset4: busy=%b done=%b carry=%b sum=%h, want all 0", busy4, done4, carry4, sum4);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy8, done8);
        end
    endtask

    task automatic test_zero_latency();
        int  cyc, bcyc;
        bit  chg;
        start_op8(8'h00, 8'h00, 1'b0);
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start: got %b want 1", busy8);
        end
        wait_done8(8'h00, 1'b0, cyc, bcyc, chg);
        checks++;
        if (cyc != 8) begin
            failures++;
            $display("FAIL latency: done after %0d cycles, want 8", cyc);
        end
        checks++;
        if (bcyc != 8) begin
            failures++;
            $display("FAIL busy_len: busy high %0d cycles, want 8", bcyc);
        end
        checks++;
        if (busy8 !== 1'b0 || sum8 !== 8'h00 || carry8 !== 1'b0) begin
            failures++;
            $display("FAIL zero_add: busy=%b sum=%h carry=%b, want 0 00 0", busy8, sum8, carry8);
        end
        tick();
        checks++;
        if (done8 !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width: done=%b one cycle after pulse, want 0", done8);
        end
    endtask

    task automatic test_carry_out();
        int  cyc, bcyc;
        bit  chg;
        start_op8(8'hFF, 8'h01, 1'b0);
        wait_done8(8'h00, 1'b0, cyc, bcyc, chg);
        checks++;
        if (cyc != 8 || sum8 !== 8'h00 || carry8 !== 1'b1) begin
            failures++;
            $display("FAIL ff_plus_1: cycles=%0d sum=%h carry=%b, want 8 00 1", cyc, sum8, carry8);
        end
        tick();
        start_op8(8'hA5, 8'h5A, 1'b1);
        wait_done8(8'h00, 1'b1, cyc, bcyc, chg);
        checks++;
        if (cyc != 8 || sum8 !== 8'h00 || carry8 !== 1'b1) begin
            failures++;
            $display("FAIL a5_5a_cin: cycles=%0d sum=%h carry=%b, want 8 00 1", cyc, sum8, carry8);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int cyc;
        int pulses;
        bit chg;
        start_op8(8'h3C, 8'h0F, 1'b0);
        cyc = 0;
        chg = 1'b0;
        while (done8 !== 1'b1 && cyc < 20) begin
            // Second start lands while RUN is in progress.
            if (cyc == 2) begin
                start8 = 1'b1;
                a8     = 8'hFF;
            end else begin
                start8 = 1'b0;
            end
            if (sum8 !== 8'h00 || carry8 !== 1'b1) chg = 1'b1;
            tick();
            cyc++;
        end
        start8 = 1'b0;
        checks++;
        if (cyc != 8 || sum8 !== 8'h4B || carry8 !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start: cycles=%0d sum=%h carry=%b, want 8 4b 0", cyc, sum8, carry8);
        end
        checks++;
        if (chg) begin
            failures++;
            $display("FAIL hold_during_run: sum/carry changed before done, want held 00/1");
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL single_done: %0d extra done pulses, want 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int  cyc, bcyc;
        bit  chg;
        start_op8(8'h11, 8'h22, 1'b0);
        wait_done8(8'h4B, 1'b0, cyc, bcyc, chg);
        checks++;
        if (done8 !== 1'b1 || sum8 !== 8'h33 || carry8 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: done=%b sum=%h carry=%b, want 1 33 0", done8, sum8, carry8);
        end
        // Start lands in the DONE cycle.
        start_op8(8'h80, 8'h80, 1'b0);
        checks++;
        if (busy8 !== 1'b1 || sum8 !== 8'h33) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b sum=%h, want 1 33", busy8, sum8);
        end
        wait_done8(8'h33, 1'b0, cyc, bcyc, chg);
        checks++;
        if (cyc != 8 || sum8 !== 8'h00 || carry8 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: cycles=%0d sum=%h carry=%b, want 8 00 1", cyc, sum8, carry8);
        end
        checks++;
        if (chg) begin
            failures++;
            $display("FAIL b2b_hold: first result not held until second done");
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int  cyc, bcyc, pulses;
        bit  chg;
        start_op8(8'h77, 8'h11, 1'b0);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, carry8, sum8} !== 11'd0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b carry=%b sum=%h, want all 0", busy8, done8, carry8, sum8);
        end
        tick();
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 === 1'b1 || busy8 === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL aborted_op: %0d cycles of busy/done after reset, want 0", pulses);
        end
        start_op8(8'h12, 8'h34, 1'b1);
        wait_done8(8'h00, 1'b0, cyc, bcyc, chg);
        checks++;
        if (cyc != 8 || sum8 !== 8'h47 || carry8 !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_op: cycles=%0d sum=%h carry=%b, want 8 47 0", cyc, sum8, carry8);
        end
        tick();
    endtask

    task automatic test_width4_sweep();
        logic [4:0] prev;
        logic [4:0] expv;
        int         cyc;
        bit         chg;
        prev = 5'd0;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    expv   = 5'(ai + bi + ci);
                    start4 = 1'b1;
                    a4     = 4'(ai);
                    b4     = 4'(bi);
                    cin4   = 1'(ci);
                    tick();
                    start4 = 1'b0;
                    a4     = 4'($urandom);
                    b4     = 4'($urandom);
                    cin4   = 1'($urandom);
                    cyc    = 0;
                    chg    = 1'b0;
                    while (done4 !== 1'b1 && cyc < 12) begin
                        if ({carry4, sum4} !== prev) chg = 1'b1;
                        tick();
                        cyc++;
                    end
                    checks++;
                    if (cyc != 4 || {carry4, sum4} !== expv) begin
                        failures++;
                        $display("FAIL w4_add a=%h b=%h cin=%0d: cycles=%0d got %h want %h",
                                 4'(ai), 4'(bi), ci, cyc, {carry4, sum4}, expv);
                    end
                    checks++;
                    if (chg) begin
                        failures++;
                        $display("FAIL w4_hold a=%h b=%h cin=%0d: result moved before done",
                                 4'(ai), 4'(bi), ci);
                    end
                    prev = expv;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_carry_out();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_width4_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
